// File: rtl/alu_seq_param.sv
// Sequential ALU: 1-cycle add/sub, radix-2 Booth multiply, restoring unsigned divide, one shared FSM.
// Latency: done at edge 2 (add/sub, div-by-zero) or WIDTH+2 (mul/div); start ignored while an op is in flight.
// Optional ALU_SEQ_REMAINDER_EN: drive the remainder on result_hi for div (otherwise result_hi=0 for div).
module alu_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] inbus_a,
    input  logic [WIDTH-1:0] inbus_b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, FIN} state_t;

    state_t           state;
    logic [1:0]       opr;
    logic [WIDTH:0]   acc;      // Booth accumulator (one guard bit) / divider remainder
    logic [WIDTH-1:0] qreg;     // operand A, Booth Q, or dividend/quotient
    logic [WIDTH-1:0] breg;     // operand B
    logic             q_m1;
    logic [CW-1:0]    cnt;
    logic             ovf_as;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] as_sum;
    logic             as_ovf;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH:0]   prod_top;
    logic             mul_ovf;

    always_comb begin
        b_eff     = opr[0] ? ~breg : breg;
        as_sum    = qreg + b_eff + {{(WIDTH-1){1'b0}}, opr[0]};
        as_ovf    = (qreg[WIDTH-1] == b_eff[WIDTH-1]) && (as_sum[WIDTH-1] != qreg[WIDTH-1]);
        m_ext     = {breg[WIDTH-1], breg};
        booth_sum = acc;
        case ({qreg[0], q_m1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        div_shift = {acc[WIDTH-1:0], qreg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, breg};
        div_ge    = div_shift >= {1'b0, breg};
        // product[2W-1:W-1] must be all-equal for the product to fit in WIDTH signed bits
        prod_top  = {acc[WIDTH-1:0], qreg[WIDTH-1]};
        mul_ovf   = !((&prod_top) || !(|prod_top));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            opr       <= 2'b00;
            acc       <= '0;
            qreg      <= '0;
            breg      <= '0;
            q_m1      <= 1'b0;
            cnt       <= '0;
            ovf_as    <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opr  <= opcode;
                        qreg <= inbus_a;
                        breg <= inbus_b;
                        acc  <= '0;
                        q_m1 <= 1'b0;
                        cnt  <= '0;
                        case (opcode)
                            2'b10:   state <= MUL;
                            2'b11:   state <= DIV;
                            default: state <= ADDSUB;
                        endcase
                    end
                end
                ADDSUB: begin
                    busy   <= 1'b1;
                    acc    <= {1'b0, as_sum};
                    ovf_as <= as_ovf;
                    state  <= FIN;
                end
                MUL: begin
                    busy <= 1'b1;
                    if (cnt == CW'(WIDTH)) begin
                        state <= FIN;
                    end else begin
                        acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                        qreg <= {booth_sum[0], qreg[WIDTH-1:1]};
                        q_m1 <= qreg[0];
                        cnt  <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    busy <= 1'b1;
                    if (breg == '0 || cnt == CW'(WIDTH)) begin
                        state <= FIN;
                    end else begin
                        acc  <= div_ge ? {1'b0, div_diff[WIDTH-1:0]} : {1'b0, div_shift[WIDTH-1:0]};
                        qreg <= {qreg[WIDTH-2:0], div_ge};
                        cnt  <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    case (opr)
                        2'b10: begin
                            result_lo <= qreg;
                            result_hi <= acc[WIDTH-1:0];
                            ovf       <= mul_ovf;
                            dbz       <= 1'b0;
                        end
                        2'b11: begin
                            result_lo <= (breg == '0) ? '1 : qreg;
`ifdef ALU_SEQ_REMAINDER_EN
                            // on divide-by-zero qreg still holds the untouched dividend
                            result_hi <= (breg == '0) ? qreg : acc[WIDTH-1:0];
`else
                            result_hi <= '0;
`endif
                            ovf       <= 1'b0;
                            dbz       <= (breg == '0);
                        end
                        default: begin
                            result_lo <= acc[WIDTH-1:0];
                            result_hi <= '0;
                            ovf       <= ovf_as;
                            dbz       <= 1'b0;
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param at WIDTH=8; honours ALU_SEQ_REMAINDER_EN for remainder expectations.
module tb_alu_seq_param;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] opcode;
    logic [7:0] inbus_a;
    logic [7:0] inbus_b;
    logic [7:0] result_lo;
    logic [7:0] result_hi;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       dbz;

    int checks = 0;
    int errors = 0;
    int n;
    logic b1;
    logic saw_done;

    alu_seq_param #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .inbus_a(inbus_a), .inbus_b(inbus_b),
        .result_lo(result_lo), .result_hi(result_hi),
        .busy(busy), .done(done), .ovf(ovf), .dbz(dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // called at a negedge; the following posedge is edge 0
    task automatic launch(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        start = 1'b1; opcode = op; inbus_a = a; inbus_b = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // returns the edge index at which done was seen (0 on timeout) and busy after edge 1
    task automatic wait_done(output int edge_n, output logic busy1);
        edge_n = 0;
        busy1  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) busy1 = busy;
            if (done) begin
                edge_n = k;
                break;
            end
        end
        if (edge_n == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; opcode = 2'b00; inbus_a = '0; inbus_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_lo", result_lo, 0);
        check("rst_hi", result_hi, 0);
        check("rst_busy_done", {busy, done, ovf, dbz}, 0);
        reset = 1'b0;

        launch(2'b00, 8'h7F, 8'h01);
        wait_done(n, b1);
        check("add_edge", n, 2);
        check("add_busy1", b1, 1);
        check("add_busy_at_done", busy, 0);
        check("add_lo", result_lo, 8'h80);
        check("add_flags", {ovf, dbz}, 2'b10);
        check("add_hi", result_hi, 0);

        launch(2'b01, 8'h05, 8'h07);
        wait_done(n, b1);
        check("sub_edge", n, 2);
        check("sub_lo", result_lo, 8'hFE);
        check("sub_ovf", ovf, 0);

        launch(2'b10, 8'hFD, 8'h07);
        wait_done(n, b1);
        check("mul1_edge", n, 10);
        check("mul1_prod", {result_hi, result_lo}, 16'hFFEB);
        check("mul1_ovf", ovf, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        launch(2'b10, 8'h40, 8'h04);
        wait_done(n, b1);
        check("mul2_prod", {result_hi, result_lo}, 16'h0100);
        check("mul2_ovf", ovf, 1);

        launch(2'b11, 8'd200, 8'd7);
        wait_done(n, b1);
        check("div_edge", n, 10);
        check("div_quot", result_lo, 8'h1C);
`ifdef ALU_SEQ_REMAINDER_EN
        check("div_rem", result_hi, 8'h04);
`else
        check("div_rem", result_hi, 8'h00);
`endif
        check("div_flags", {ovf, dbz}, 2'b00);

        launch(2'b11, 8'h2A, 8'h00);
        wait_done(n, b1);
        check("dbz_edge", n, 2);
        check("dbz_quot", result_lo, 8'hFF);
        check("dbz_flag", dbz, 1);
`ifdef ALU_SEQ_REMAINDER_EN
        check("dbz_rem", result_hi, 8'h2A);
`else
        check("dbz_rem", result_hi, 8'h00);
`endif

        // start pulses with different operands while the multiply is running
        launch(2'b10, 8'hFD, 8'h07);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                n = k;
                break;
            end
            if (k >= 3 && k <= 6) begin
                start = 1'b1; opcode = 2'b00; inbus_a = 8'h11; inbus_b = 8'h22;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("busy_ign_edge", n, 10);
        check("busy_ign_prod", {result_hi, result_lo}, 16'hFFEB);

        // back-to-back: start in the done cycle
        launch(2'b00, 8'h10, 8'h20);
        wait_done(n, b1);
        check("b2b_edge", n, 2);
        check("b2b_lo", result_lo, 8'h30);
        check("b2b_flags", {ovf, dbz}, 2'b00);

        // reset after iteration 4 of a multiply
        launch(2'b10, 8'h05, 8'h06);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_out", {result_hi, result_lo, ovf, dbz}, 0);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("rst_no_done", saw_done, 0);

        launch(2'b00, 8'h03, 8'h04);
        wait_done(n, b1);
        check("post_rst_edge", n, 2);
        check("post_rst_lo", result_lo, 8'h07);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
